piso_tx: RTL and testbench

Parallel-in serial-out transmitter, the transmit end of the serial link our SIPO receiver captures. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock with s_valid/s_last framing. Back-to-back words stream with no idle gap. It sits between a parallel data source and a single-wire serial path feeding sipo_1-style receivers.

---
 rtl/piso_tx.sv | 63 ++++++
 tb/tb_piso_tx.sv | 104 ++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter with valid/ready input and gapless word streaming
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] p_in,
    input  logic             p_valid,
    output logic             p_ready,
    output logic             s_out,
    output logic             s_valid,
    output logic             s_last,
    output logic             busy
);
    typedef enum logic {IDLE, SHIFT} state_t;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    state_t          state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   nxt;
    logic            accept;
    function automatic logic pick(input logic [WIDTH-1:0] w, input logic [CW-1:0] i);
        logic [CW-1:0] idx;
        idx = MSB_FIRST ? LAST - i : i;
        return w[idx];
    endfunction
    always_comb begin
        busy    = state == SHIFT;
        p_ready = (state == IDLE) || (state == SHIFT && s_last);
        accept  = p_valid && p_ready;
        nxt     = cnt + 1'b1;
    end
    // cnt always holds the index of the bit currently on s_out
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            sreg    <= '0;
            cnt     <= '0;
            s_out   <= 1'b0;
            s_valid <= 1'b0;
            s_last  <= 1'b0;
        end else if (accept) begin
            state   <= SHIFT;
            sreg    <= p_in;
            cnt     <= '0;
            s_out   <= pick(p_in, '0);
            s_valid <= 1'b1;
            s_last  <= 1'b0;
        end else if (state == SHIFT && !s_last) begin
            cnt    <= nxt;
            s_out  <= pick(sreg, nxt);
            s_last <= nxt == LAST;
        end else begin
            state   <= IDLE;
            cnt     <= '0;
            s_out   <= 1'b0;
            s_valid <= 1'b0;
            s_last  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: table-driven checks of piso_tx (4-bit MSB-first) plus an 8-bit LSB-first loopback sequence
module tb_piso_tx;
    logic       clk, rst;
    logic [3:0] pin;
    logic       pv, pr, so, sv, sl, bz;
    logic [7:0] pin8;
    logic       pv8, pr8, so8, sv8, sl8, bz8;
    int checks = 0, errors = 0;

    piso_tx #(.WIDTH(4), .MSB_FIRST(1)) dut4 (
        .clk(clk), .rst(rst), .p_in(pin), .p_valid(pv), .p_ready(pr),
        .s_out(so), .s_valid(sv), .s_last(sl), .busy(bz)
    );
    piso_tx #(.WIDTH(8), .MSB_FIRST(0)) dut8 (
        .clk(clk), .rst(rst), .p_in(pin8), .p_valid(pv8), .p_ready(pr8),
        .s_out(so8), .s_valid(sv8), .s_last(sl8), .busy(bz8)
    );

    always #5 clk = ~clk;

    // exp = {p_ready, s_out, s_valid, s_last, busy} seen before the edge that samples the inputs
    typedef struct {
        logic       rst;
        logic       pv;
        logic [3:0] pin;
        logic [4:0] exp;
    } vec_t;
    vec_t q[$];

    task automatic add(input logic r, input logic p, input logic [3:0] d, input logic [4:0] e);
        q.push_back('{r, p, d, e});
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    logic [7:0] rx;
    logic       exp8[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        clk = 0; rst = 0; pv = 1; pin = 4'hF; pv8 = 0; pin8 = '0; rx = '0;
        @(posedge clk);
        add(0, 1, 4'hF,    5'b10000);
        add(1, 1, 4'b1011, 5'b10000);
        add(1, 0, 4'b0000, 5'b01101);
        add(1, 0, 4'b0000, 5'b00101);
        add(1, 0, 4'b0000, 5'b01101);
        add(1, 0, 4'b0000, 5'b11111);
        add(1, 0, 4'b0000, 5'b10000);
        add(1, 1, 4'b1011, 5'b10000);
        add(1, 0, 4'b0000, 5'b01101);
        add(1, 0, 4'b0000, 5'b00101);
        add(1, 0, 4'b0000, 5'b01101);
        add(1, 1, 4'b0110, 5'b11111);
        add(1, 0, 4'b0000, 5'b00101);
        add(1, 0, 4'b0000, 5'b01101);
        add(1, 0, 4'b0000, 5'b01101);
        add(1, 0, 4'b0000, 5'b10111);
        add(1, 1, 4'b1100, 5'b10000);
        add(1, 0, 4'b0000, 5'b01101);
        add(1, 1, 4'b0101, 5'b01101);
        add(1, 1, 4'b0101, 5'b00101);
        add(1, 1, 4'b0101, 5'b10111);
        add(1, 0, 4'b1111, 5'b00101);
        add(1, 0, 4'b1111, 5'b01101);
        add(1, 0, 4'b0000, 5'b00101);
        add(1, 0, 4'b0000, 5'b11111);
        add(1, 1, 4'b1001, 5'b10000);
        add(1, 0, 4'b0000, 5'b01101);
        add(0, 0, 4'b0000, 5'b00101);
        add(1, 0, 4'b0000, 5'b10000);
        add(1, 0, 4'b0000, 5'b10000);
        add(1, 1, 4'b0011, 5'b10000);
        add(1, 0, 4'b0000, 5'b00101);
        add(1, 0, 4'b0000, 5'b00101);
        add(1, 0, 4'b0000, 5'b01101);
        add(1, 0, 4'b0000, 5'b11111);
        add(1, 0, 4'b0000, 5'b10000);
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            rst = q[i].rst; pv = q[i].pv; pin = q[i].pin;
            #1 chk($sformatf("row%0d", i), {3'b000, pr, so, sv, sl, bz}, {3'b000, q[i].exp});
        end
        @(negedge clk);
        rst = 1; pv = 0; pv8 = 1; pin8 = 8'hA5;
        #1 chk("w8_idle", {6'b0, pr8, sv8}, 8'b0000_0010);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pv8 = 0; pin8 = 8'h00;
            #1 chk($sformatf("w8_bit%0d", i), {5'b0, so8, sv8, sl8}, {5'b0, exp8[i], 1'b1, i == 7});
            if (sv8) rx = {so8, rx[7:1]};
        end
        @(negedge clk);
        #1 chk("w8_done", {6'b0, sv8, bz8}, 8'h00);
        chk("w8_loopback", rx, 8'hA5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
